// File: rtl/uart_proto_pkg.sv
// -----------------------------------------------------------------------------
// uart_proto_pkg
//   Shared UART command-byte protocol definitions for the game-state /
//   operate / target packer. A command byte is {payload[5:0], type[1:0]}.
//   Contents:
//     - TYPE_*      two-bit type codes carried in byte bits [1:0]
//     - OP_*        bit positions of the one-hot operate code
//     - GS_*        game-state codes
//     - IDLE_BYTE   the "nothing to send" byte seen by the UART
//     - tx_state_t  packer FSM states
//     - packByte    helper that assembles a command byte
// -----------------------------------------------------------------------------
package uart_proto_pkg;

  // Command byte type codes (byte bits [1:0]); 2'b00 is never used so a
  // real command byte can never equal IDLE_BYTE.
  localparam logic [1:0] TYPE_GAME    = 2'b01;
  localparam logic [1:0] TYPE_OPERATE = 2'b10;
  localparam logic [1:0] TYPE_TARGET  = 2'b11;

  // Operate one-hot bit positions
  localparam int OP_GET      = 0;
  localparam int OP_PUT      = 1;
  localparam int OP_INTERACT = 2;
  localparam int OP_MOVE     = 3;
  localparam int OP_THROW    = 4;

  // Useful field widths of each channel
  localparam int GS_BITS  = 2;
  localparam int OP_BITS  = 5;
  localparam int TGT_BITS = 6;

  // Game-state codes
  localparam logic [1:0] GS_START = 2'b01;
  localparam logic [1:0] GS_STOP  = 2'b10;

  // Byte the UART interprets as "nothing to send"
  localparam logic [7:0] IDLE_BYTE = 8'h00;

  // Packer FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } tx_state_t;

  // Assemble a command byte from a 6-bit payload and a type code
  function automatic logic [7:0] packByte(input logic [5:0] payload,
                                          input logic [1:0] kind);
    return {payload, kind};
  endfunction

endpackage

// File: rtl/change_detect.sv
// -----------------------------------------------------------------------------
// change_detect
//   Per-channel snapshot register with a pending flag. Whenever the (already
//   masked) input differs from the stored snapshot, the snapshot follows the
//   input and the channel becomes pending. A change on a channel that is
//   already pending just overwrites the snapshot, so only the newest value is
//   ever sent.
//   Ports:
//     clock       block clock
//     reset       asynchronous, active-low reset
//     i_value     masked channel value to watch
//     i_clear     the packer has taken this channel's byte
//     i_force     mark pending without a value change (periodic refresh)
//     o_snapshot  last value seen on the channel
//     o_pending   a byte for this channel is waiting to be sent
// -----------------------------------------------------------------------------
module change_detect #(
  parameter int WIDTH = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_clear,
  input  logic             i_force,
  output logic [WIDTH-1:0] o_snapshot,
  output logic             o_pending
);

  logic [WIDTH-1:0] r_snapshot;
  logic             r_pending;

  // Snapshot and pending flag. A value change wins over a clear in the
  // same cycle: the packer has latched the old snapshot, and the new value
  // must still follow as a second byte.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_snapshot <= '0;
      r_pending  <= 1'b0;
    end else begin
      if (i_value != r_snapshot) begin
        r_snapshot <= i_value;
        r_pending  <= 1'b1;
      end else if (i_force) begin
        r_pending  <= 1'b1;
      end else if (i_clear) begin
        r_pending  <= 1'b0;
      end
    end
  end

  assign o_snapshot = r_snapshot;
  assign o_pending  = r_pending;

endmodule

// File: rtl/uart_tx_packer.sv
// -----------------------------------------------------------------------------
// uart_tx_packer
//   Packs game-state, verified-operation and target-machine values into UART
//   command bytes {payload[5:0], type[1:0]} and meters them into the UART one
//   at a time. Each channel has change detection and a pending flag; a fixed
//   priority arbiter (game state > operate > target) picks the next byte. A
//   byte is held on tx_bits until the UART's one-cycle ready pulse or until
//   TIMEOUT_CYCLES pass, then tx_bits returns to 8'h00 for at least one cycle
//   so the UART always sees a distinct new byte. The current target is re-sent
//   after REFRESH_CYCLES quiet cycles (0 disables this).
//   Ports:
//     clock       UART clock (16 x baud), the only clock
//     reset       asynchronous, active-low reset
//     game_state  game-state code, bits [1:0] used
//     operate     verified operation, one-hot in bits [4:0], 0 = none
//     target      target machine id, bits [5:0] used
//     tx_ready    one-cycle pulse from the UART when a byte has gone out
//     tx_bits     byte to transmit, 8'h00 = nothing to send
//     busy        a byte is in flight
//     drop_count  saturating count of bytes abandoned on timeout
// -----------------------------------------------------------------------------
module uart_tx_packer
  import uart_proto_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int REFRESH_CYCLES = 65535
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] game_state,
  input  logic [7:0] operate,
  input  logic [7:0] target,
  input  logic       tx_ready,
  output logic [7:0] tx_bits,
  output logic       busy,
  output logic [7:0] drop_count
);

  localparam int              TO_W      = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
  localparam int              RF_W      = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) + 1 : 1;
  localparam logic [RF_W-1:0] RF_LAST   = RF_W'(REFRESH_CYCLES - 1);
  localparam bit              RF_ENABLE = (REFRESH_CYCLES != 0);

  logic [GS_BITS-1:0]  w_gsMasked;
  logic [OP_BITS-1:0]  w_opMasked;
  logic [TGT_BITS-1:0] w_tgMasked;
  logic [GS_BITS-1:0]  w_gsSnap;
  logic [OP_BITS-1:0]  w_opSnap;
  logic [TGT_BITS-1:0] w_tgSnap;
  logic                w_gsPend;
  logic                w_opPend;
  logic                w_tgPend;
  logic                w_gsClear;
  logic                w_opClear;
  logic                w_tgClear;
  logic                w_anyPending;
  logic [7:0]          w_winByte;
  logic                w_unused;

  tx_state_t           r_state;
  tx_state_t           w_stateNext;
  logic [7:0]          r_byte;
  logic [7:0]          r_txBits;
  logic [7:0]          w_txNext;
  logic                w_load;
  logic                w_drop;
  logic [TO_W-1:0]     r_toCnt;
  logic [TO_W-1:0]     w_toCntNext;
  logic [RF_W-1:0]     r_rfCnt;
  logic [RF_W-1:0]     w_rfCntNext;
  logic                w_rfIdle;
  logic                w_refreshHit;
  logic [7:0]          r_dropCount;
  logic [7:0]          w_dropNext;

  // Only the documented bits of each input carry meaning.
  assign w_gsMasked = game_state[GS_BITS-1:0];
  assign w_opMasked = {operate[OP_THROW], operate[OP_MOVE], operate[OP_INTERACT],
                       operate[OP_PUT], operate[OP_GET]};
  assign w_tgMasked = target[TGT_BITS-1:0];
  assign w_unused   = ^{game_state[7:GS_BITS], operate[7:OP_BITS], target[7:TGT_BITS]};

  change_detect #(.WIDTH(GS_BITS)) u_gameDetect (
    .clock      (clock),
    .reset      (reset),
    .i_value    (w_gsMasked),
    .i_clear    (w_gsClear),
    .i_force    (1'b0),
    .o_snapshot (w_gsSnap),
    .o_pending  (w_gsPend)
  );

  change_detect #(.WIDTH(OP_BITS)) u_operateDetect (
    .clock      (clock),
    .reset      (reset),
    .i_value    (w_opMasked),
    .i_clear    (w_opClear),
    .i_force    (1'b0),
    .o_snapshot (w_opSnap),
    .o_pending  (w_opPend)
  );

  change_detect #(.WIDTH(TGT_BITS)) u_targetDetect (
    .clock      (clock),
    .reset      (reset),
    .i_value    (w_tgMasked),
    .i_clear    (w_tgClear),
    .i_force    (w_refreshHit),
    .o_snapshot (w_tgSnap),
    .o_pending  (w_tgPend)
  );

  assign w_anyPending = w_gsPend | w_opPend | w_tgPend;

  // Fixed-priority arbiter: game state, then operate, then target. Only the
  // winning channel's pending flag is cleared when the FSM latches a byte.
  always_comb begin
    w_gsClear = 1'b0;
    w_opClear = 1'b0;
    w_tgClear = 1'b0;
    w_winByte = packByte(w_tgSnap, TYPE_TARGET);
    if (w_gsPend) begin
      w_winByte = packByte({4'b0000, w_gsSnap}, TYPE_GAME);
      w_gsClear = w_load;
    end else if (w_opPend) begin
      w_winByte = packByte({1'b0, w_opSnap}, TYPE_OPERATE);
      w_opClear = w_load;
    end else begin
      w_tgClear = w_load & w_tgPend;
    end
  end

  // Next-state and output logic. tx_bits is registered, so the value chosen
  // here appears one cycle later: the byte becomes visible at the end of
  // SEND and drops back to 8'h00 as the FSM leaves WAIT. A ready pulse is
  // only looked at in WAIT; a pulse that coincides with the final timeout
  // cycle counts as success.
  always_comb begin
    w_stateNext = r_state;
    w_txNext    = r_txBits;
    w_toCntNext = r_toCnt;
    w_load      = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_txNext = IDLE_BYTE;
        if (w_anyPending) begin
          w_load      = 1'b1;
          w_stateNext = ST_SEND;
        end
      end
      ST_SEND: begin
        w_txNext    = r_byte;
        w_toCntNext = '0;
        w_stateNext = ST_WAIT;
      end
      ST_WAIT: begin
        w_toCntNext = r_toCnt + TO_W'(1);
        if (tx_ready) begin
          w_txNext    = IDLE_BYTE;
          w_stateNext = ST_GAP;
        end else if (r_toCnt == TO_LAST) begin
          w_drop      = 1'b1;
          w_txNext    = IDLE_BYTE;
          w_stateNext = ST_GAP;
        end
      end
      ST_GAP: begin
        w_txNext    = IDLE_BYTE;
        w_stateNext = ST_IDLE;
      end
      default: begin
        w_txNext    = IDLE_BYTE;
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Refresh timer: runs only while idle with nothing queued, re-queues the
  // current target when it expires, and restarts whenever a byte is sent.
  always_comb begin
    w_rfIdle     = RF_ENABLE && (r_state == ST_IDLE) && !w_anyPending;
    w_refreshHit = w_rfIdle && (r_rfCnt == RF_LAST);
    w_rfCntNext  = r_rfCnt;
    if (r_state == ST_SEND) begin
      w_rfCntNext = '0;
    end else if (w_refreshHit) begin
      w_rfCntNext = '0;
    end else if (w_rfIdle) begin
      w_rfCntNext = r_rfCnt + RF_W'(1);
    end
  end

  // Drop counter sticks at 255 instead of wrapping.
  always_comb begin
    w_dropNext = r_dropCount;
    if (w_drop && (r_dropCount != 8'hFF)) begin
      w_dropNext = r_dropCount + 8'd1;
    end
  end

  // State, byte latch, output byte and counters. Reset clears tx_bits at
  // once, so an in-flight byte is abandoned rather than resumed.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_byte      <= IDLE_BYTE;
      r_txBits    <= IDLE_BYTE;
      r_toCnt     <= '0;
      r_rfCnt     <= '0;
      r_dropCount <= 8'd0;
    end else begin
      r_state     <= w_stateNext;
      r_txBits    <= w_txNext;
      r_toCnt     <= w_toCntNext;
      r_rfCnt     <= w_rfCntNext;
      r_dropCount <= w_dropNext;
      if (w_load) begin
        r_byte <= w_winByte;
      end
    end
  end

  assign tx_bits    = r_txBits;
  assign busy       = (r_state == ST_SEND) || (r_state == ST_WAIT);
  assign drop_count = r_dropCount;

endmodule

// File: tb/tb_uart_tx_packer.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_packer
//   Directed bench for uart_tx_packer. The main instance has refresh
//   disabled and a short timeout; a second instance with REFRESH_CYCLES=100
//   shares the data inputs but has its own ready pulse, and is only examined
//   in the refresh scenario. Expected bytes are worked out by hand from the
//   {payload[5:0], type[1:0]} format.
// -----------------------------------------------------------------------------
module tb_uart_tx_packer;

  localparam int TIMEOUT = 200;
  localparam int REFRESH = 100;

  logic       clock;
  logic       resetN;
  logic [7:0] gameState;
  logic [7:0] operate;
  logic [7:0] target;
  logic       txReady;
  logic       txReadyRef;
  logic [7:0] txBits;
  logic       busy;
  logic [7:0] dropCount;
  logic [7:0] txBitsRef;
  logic       busyRef;
  logic [7:0] dropCountRef;

  int checkCount = 0;
  int errorCount = 0;

  uart_tx_packer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .REFRESH_CYCLES (0)
  ) dut (
    .clock      (clock),
    .reset      (resetN),
    .game_state (gameState),
    .operate    (operate),
    .target     (target),
    .tx_ready   (txReady),
    .tx_bits    (txBits),
    .busy       (busy),
    .drop_count (dropCount)
  );

  uart_tx_packer #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .REFRESH_CYCLES (REFRESH)
  ) dutRef (
    .clock      (clock),
    .reset      (resetN),
    .game_state (gameState),
    .operate    (operate),
    .target     (target),
    .tx_ready   (txReadyRef),
    .tx_bits    (txBitsRef),
    .busy       (busyRef),
    .drop_count (dropCountRef)
  );

  // Free-running clock, 10 time units per cycle
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Hard stop in case something stalls far beyond the scenario length
  initial begin
    #1500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Count a comparison and report it if the observed value is wrong
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one clock and settle just after the active edge
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Drive all three data channels together
  task automatic applyStimulus(input logic [7:0] gs, input logic [7:0] op,
                               input logic [7:0] tg);
    gameState = gs;
    operate   = op;
    target    = tg;
  endtask

  function automatic logic [7:0] readTx(input bit useRef);
    return useRef ? txBitsRef : txBits;
  endfunction

  // Wait (bounded) until the chosen instance shows a byte, then check it
  task automatic waitForByte(input string tag, input logic [7:0] expected,
                             input int budget, input bit useRef);
    int n;
    n = 0;
    while (readTx(useRef) == 8'h00 && n < budget) begin
      tick();
      n++;
    end
    checkOutput(tag, {24'd0, readTx(useRef)}, {24'd0, expected});
  endtask

  // One-cycle ready pulse to the chosen instance
  task automatic pulseReady(input bit useRef);
    if (useRef) txReadyRef = 1'b1;
    else        txReady    = 1'b1;
    tick();
    txReadyRef = 1'b0;
    txReady    = 1'b0;
  endtask

  // Scenario sequence
  initial begin
    int held;
    int n;
    int stalls;
    int spurious;

    resetN     = 1'b0;
    txReady    = 1'b0;
    txReadyRef = 1'b0;
    applyStimulus(8'd0, 8'd0, 8'd0);
    repeat (3) tick();

    checkOutput("resetTx", {24'd0, txBits}, 32'h00);
    checkOutput("resetBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetDrop", {24'd0, dropCount}, 32'd0);
    resetN = 1'b1;
    repeat (3) tick();
    checkOutput("quietAfterReset", {24'd0, txBits}, 32'h00);

    // Target 5 -> 8'h17, visible on the third edge after the change
    applyStimulus(8'd0, 8'd0, 8'd5);
    tick();
    tick();
    checkOutput("latencyEarly", {24'd0, txBits}, 32'h00);
    tick();
    checkOutput("latencyByte", {24'd0, txBits}, 32'h17);
    checkOutput("latencyBusy", {31'd0, busy}, 32'd1);
    repeat (5) tick();
    checkOutput("latencyHold", {24'd0, txBits}, 32'h17);
    pulseReady(1'b0);
    checkOutput("gapByte", {24'd0, txBits}, 32'h00);
    checkOutput("gapBusy", {31'd0, busy}, 32'd0);
    tick();

    // All three channels change together: game, operate, target in order
    applyStimulus(8'h01, 8'h04, 8'd2);
    waitForByte("simulGame", 8'h05, 10, 1'b0);
    pulseReady(1'b0);
    checkOutput("simulGap", {24'd0, txBits}, 32'h00);
    waitForByte("simulOperate", 8'h12, 10, 1'b0);
    pulseReady(1'b0);
    waitForByte("simulTarget", 8'h0B, 10, 1'b0);
    pulseReady(1'b0);

    // Operate edge to GET and back to none
    applyStimulus(8'h01, 8'h01, 8'd2);
    waitForByte("operateGet", 8'h06, 10, 1'b0);
    pulseReady(1'b0);
    applyStimulus(8'h01, 8'h00, 8'd2);
    waitForByte("operateRelease", 8'h02, 10, 1'b0);
    pulseReady(1'b0);
    repeat (5) tick();
    checkOutput("quietAfterOperate", {24'd0, txBits}, 32'h00);

    // A ready pulse during SEND must not end the byte early
    applyStimulus(8'h01, 8'h00, 8'd13);
    tick();
    tick();
    txReady = 1'b1;
    tick();
    txReady = 1'b0;
    checkOutput("readyInSend", {24'd0, txBits}, 32'h37);
    tick();
    checkOutput("readyInSendHold", {24'd0, txBits}, 32'h37);
    pulseReady(1'b0);

    // No ready pulse: byte held for exactly TIMEOUT cycles, then dropped
    applyStimulus(8'h01, 8'h00, 8'd7);
    waitForByte("timeoutByte", 8'h1F, 10, 1'b0);
    held = 0;
    while (txBits != 8'h00 && held < 2 * TIMEOUT) begin
      held++;
      tick();
    end
    checkOutput("timeoutHeld", held, TIMEOUT);
    checkOutput("timeoutDrop", {24'd0, dropCount}, 32'd1);
    checkOutput("timeoutBusy", {31'd0, busy}, 32'd0);
    tick();

    // Ready arriving on the last timeout cycle counts as success
    applyStimulus(8'h01, 8'h00, 8'd12);
    waitForByte("tieByte", 8'h33, 10, 1'b0);
    repeat (TIMEOUT - 1) tick();
    checkOutput("tieHoldLast", {24'd0, txBits}, 32'h33);
    pulseReady(1'b0);
    checkOutput("tieRelease", {24'd0, txBits}, 32'h00);
    checkOutput("tieNoDrop", {24'd0, dropCount}, 32'd1);

    // 300 more consecutive drops; the counter must stop at 255
    stalls = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(8'h01, 8'h00, (i % 2 == 1) ? 8'd10 : 8'd11);
      n = 0;
      while (txBits == 8'h00 && n < 10) begin
        tick();
        n++;
      end
      if (n >= 10) stalls++;
      n = 0;
      while (txBits != 8'h00 && n < TIMEOUT + 50) begin
        tick();
        n++;
      end
      if (n >= TIMEOUT + 50) stalls++;
      if (i == 252) checkOutput("dropAt254", {24'd0, dropCount}, 32'd254);
      if (i == 253) checkOutput("dropAt255", {24'd0, dropCount}, 32'd255);
    end
    checkOutput("dropLoopStalls", stalls, 0);
    checkOutput("dropSaturated", {24'd0, dropCount}, 32'd255);

    // Reset in the middle of WAIT clears everything asynchronously
    applyStimulus(8'h01, 8'h08, 8'd10);
    waitForByte("resetMidByte", 8'h22, 10, 1'b0);
    repeat (3) tick();
    #2;
    resetN = 1'b0;
    #1;
    checkOutput("resetMidTx", {24'd0, txBits}, 32'h00);
    checkOutput("resetMidBusy", {31'd0, busy}, 32'd0);
    checkOutput("resetMidDrop", {24'd0, dropCount}, 32'd0);
    applyStimulus(8'd0, 8'd0, 8'd0);
    tick();
    tick();
    resetN = 1'b1;
    spurious = 0;
    repeat (30) begin
      tick();
      if (txBits != 8'h00) spurious++;
    end
    checkOutput("noResendAfterReset", spurious, 0);

    // Refresh instance: target 9 -> 8'h27, re-sent after the idle period.
    // After the ready edge: GAP, then 100 idle counts, latch, SEND = 103.
    applyStimulus(8'd0, 8'd0, 8'd9);
    waitForByte("refreshFirst", 8'h27, 10, 1'b1);
    pulseReady(1'b1);
    n = 0;
    while (txBitsRef == 8'h00 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("refreshInterval", n, 103);
    checkOutput("refreshByte", {24'd0, txBitsRef}, 32'h27);
    pulseReady(1'b1);

    // A transmission part-way through the idle period restarts the timer
    repeat (50) tick();
    applyStimulus(8'h02, 8'd0, 8'd9);
    waitForByte("refreshGame", 8'h09, 10, 1'b1);
    pulseReady(1'b1);
    n = 0;
    while (txBitsRef == 8'h00 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("refreshRestart", n, 103);
    checkOutput("refreshRestartByte", {24'd0, txBitsRef}, 32'h27);
    pulseReady(1'b1);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
